// File: rtl/call_ret_sequencer.sv
// Program-counter sequencer with a subroutine return-address stack.
// BSR pushes pc+1 and jumps to target; RET pops the return address into pc.
module call_ret_sequencer #(
  parameter int unsigned        ADDR_W   = 8,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       bsr,
  input  logic                       ret,
  input  logic [ADDR_W-1:0]          target,
  input  logic                       err_clr,
  output logic [ADDR_W-1:0]          pc,
  output logic [ADDR_W-1:0]          top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic [2:0]                 err
);

  localparam int unsigned DepthW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [ADDR_W-1:0] stack_q [DEPTH];
  logic [ADDR_W-1:0] stack_d [DEPTH];
  logic [DepthW-1:0] depth_q, depth_d;
  logic [2:0]        err_q, err_d, err_ev;
  logic              is_empty, is_full;

  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == DepthW'(DEPTH));
  assign pc_inc   = pc_q + ADDR_W'(1);

  // Entry 0 is the top; entries at or above depth_q are kept at zero.
  always_comb begin
    pc_d    = pc_q;
    stack_d = stack_q;
    depth_d = depth_q;
    err_ev  = 3'b000;
    if (en) begin
      unique case ({bsr, ret})
        2'b00: pc_d = pc_inc;
        2'b10: begin
          for (int i = 1; i < int'(DEPTH); i++) stack_d[i] = stack_q[i-1];
          stack_d[0] = pc_inc;
          pc_d       = target;
          if (is_full) err_ev[0] = 1'b1;
          else         depth_d   = depth_q + DepthW'(1);
        end
        2'b01: begin
          if (is_empty) begin
            pc_d      = pc_inc;
            err_ev[1] = 1'b1;
          end else begin
            pc_d = stack_q[0];
            for (int i = 0; i < int'(DEPTH) - 1; i++) stack_d[i] = stack_q[i+1];
            stack_d[DEPTH-1] = '0;
            depth_d          = depth_q - DepthW'(1);
          end
        end
        2'b11: err_ev[2] = 1'b1;
        default: ;
      endcase
    end
    // A new error event wins over a simultaneous clear.
    err_d = (err_clr ? 3'b000 : err_q) | err_ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      stack_q <= '{default: '0};
      depth_q <= '0;
      err_q   <= 3'b000;
    end else begin
      pc_q    <= pc_d;
      stack_q <= stack_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  assign pc    = pc_q;
  assign top   = is_empty ? '0 : stack_q[0];
  assign depth = depth_q;
  assign empty = is_empty;
  assign full  = is_full;
  assign err   = err_q;

endmodule

// File: tb/tb_call_ret_sequencer.sv
// Scoreboard bench for call_ret_sequencer: queue-based return-stack model,
// directed scenarios followed by randomized commands.
module tb_call_ret_sequencer;

  localparam int DEPTH = 4;

  logic       clk, rst_n, en, bsr, ret, err_clr;
  logic [7:0] target, pc, top;
  logic [2:0] depth;
  logic       empty, full;
  logic [2:0] err;

  call_ret_sequencer #(.ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bsr(bsr), .ret(ret), .target(target),
    .err_clr(err_clr), .pc(pc), .top(top), .depth(depth), .empty(empty),
    .full(full), .err(err)
  );

  typedef struct {
    logic [7:0] pc;
    logic [7:0] top;
    int         depth;
    logic       empty;
    logic       full;
    logic [2:0] err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: the return stack as a queue, front = most recent call.
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic [2:0] m_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  task automatic model_reset();
    m_pc  = 8'h00;
    m_stk.delete();
    m_err = 3'b000;
  endtask

  task automatic step(input logic e, input logic b, input logic r,
                      input logic [7:0] t, input logic c);
    logic [2:0] ev;
    exp_t       x;
    @(negedge clk);
    en = e; bsr = b; ret = r; target = t; err_clr = c;
    ev = 3'b000;
    if (e) begin
      if (b && r) begin
        ev[2] = 1'b1;
      end else if (b) begin
        if (m_stk.size() == DEPTH) begin
          void'(m_stk.pop_back());
          ev[0] = 1'b1;
        end
        m_stk.push_front(m_pc + 8'd1);
        m_pc = t;
      end else if (r) begin
        if (m_stk.size() == 0) begin
          m_pc  = m_pc + 8'd1;
          ev[1] = 1'b1;
        end else begin
          m_pc = m_stk.pop_front();
        end
      end else begin
        m_pc = m_pc + 8'd1;
      end
    end
    m_err   = (c ? 3'b000 : m_err) | ev;
    x.pc    = m_pc;
    x.top   = (m_stk.size() > 0) ? m_stk[0] : 8'h00;
    x.depth = m_stk.size();
    x.empty = (m_stk.size() == 0);
    x.full  = (m_stk.size() == DEPTH);
    x.err   = m_err;
    exp_q.push_back(x);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0; bsr = 1'b0; ret = 1'b0; err_clr = 1'b0; target = 8'h00;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one expectation per clock edge that had stimulus behind it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", int'(pc), int'(e.pc));
        chk("sb_top", int'(top), int'(e.top));
        chk("sb_depth", int'(depth), e.depth);
        chk("sb_empty", int'(empty), int'(e.empty));
        chk("sb_full", int'(full), int'(e.full));
        chk("sb_err", int'(err), int'(e.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r, cmd;
    rst_n = 1'b0; en = 1'b0; bsr = 1'b0; ret = 1'b0; err_clr = 1'b0; target = 8'h00;
    model_reset();
    #2;
    chk("rst_pc", int'(pc), 0);
    chk("rst_depth", int'(depth), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_top", int'(top), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain increment and wrap.
    repeat (3) step(1, 0, 0, 8'h00, 0);
    settle();
    chk("p1_pc3", int'(pc), 'h03);
    step(1, 1, 0, 8'hFE, 0);
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    settle();
    chk("p1_wrap", int'(pc), 'h00);
    step(1, 0, 1, 8'h00, 0);
    settle();
    chk("p1_ret", int'(pc), 'h04);

    // Single call/return.
    do_reset();
    repeat (16) step(1, 0, 0, 8'h00, 0);
    step(1, 1, 0, 8'h40, 0);
    settle();
    chk("p2_pc", int'(pc), 'h40);
    chk("p2_top", int'(top), 'h11);
    chk("p2_depth", int'(depth), 1);
    step(1, 0, 1, 8'h00, 0);
    settle();
    chk("p2_ret_pc", int'(pc), 'h11);
    chk("p2_ret_empty", int'(empty), 1);
    chk("p2_ret_err", int'(err), 0);

    // Overflow, full unwind, underflow.
    do_reset();
    for (int i = 1; i <= 5; i++) step(1, 1, 0, 8'(i * 16), 0);
    settle();
    chk("p3_full", int'(full), 1);
    chk("p3_depth", int'(depth), 4);
    chk("p3_err", int'(err), 'b001);
    chk("p3_top", int'(top), 'h41);
    repeat (4) step(1, 0, 1, 8'h00, 0);
    settle();
    chk("p3_unwind_pc", int'(pc), 'h11);
    step(1, 0, 1, 8'h00, 0);
    settle();
    chk("p3_under_pc", int'(pc), 'h12);
    chk("p3_under_err", int'(err), 'b011);

    // Conflict and clear.
    do_reset();
    step(1, 1, 0, 8'h40, 0);
    step(1, 1, 1, 8'h77, 0);
    settle();
    chk("p4_conf_pc", int'(pc), 'h40);
    chk("p4_conf_depth", int'(depth), 1);
    chk("p4_conf_err", int'(err), 'b100);
    step(1, 0, 0, 8'h00, 1);
    settle();
    chk("p4_clr", int'(err), 0);
    step(1, 0, 1, 8'h00, 0);
    step(1, 0, 1, 8'h00, 1);
    settle();
    chk("p4_set_wins", int'(err), 'b010);

    // Enable freeze.
    do_reset();
    step(1, 1, 0, 8'h20, 0);
    step(1, 1, 0, 8'h30, 0);
    repeat (3) step(0, 1, 0, 8'h99, 0);
    settle();
    chk("p5_frz_pc", int'(pc), 'h30);
    chk("p5_frz_top", int'(top), 'h21);
    chk("p5_frz_depth", int'(depth), 2);
    step(1, 1, 0, 8'h99, 0);
    settle();
    chk("p5_go_pc", int'(pc), 'h99);
    chk("p5_go_depth", int'(depth), 3);

    // Async reset mid-operation.
    do_reset();
    step(1, 1, 0, 8'h10, 0);
    step(1, 1, 0, 8'h20, 0);
    step(1, 1, 0, 8'h30, 0);
    step(1, 1, 0, 8'h34, 0);
    step(1, 1, 0, 8'h50, 0);
    step(1, 0, 1, 8'h00, 0);
    settle();
    chk("p6_pre_pc", int'(pc), 'h35);
    chk("p6_pre_depth", int'(depth), 3);
    chk("p6_pre_err", int'(err), 'b001);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("p6_async_pc", int'(pc), 0);
    chk("p6_async_depth", int'(depth), 0);
    chk("p6_async_err", int'(err), 0);
    chk("p6_async_top", int'(top), 0);
    en = 1'b0; bsr = 1'b0; ret = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("p6_hold_pc", int'(pc), 0);
    chk("p6_hold_depth", int'(depth), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized commands against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      r   = int'($urandom_range(0, 99));
      cmd = int'($urandom_range(0, 9));
      step(r < 90, (cmd >= 4 && cmd <= 6) || cmd == 9, cmd >= 7,
           8'($urandom), $urandom_range(0, 11) == 0);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/call_ret_sequencer.md
Name: call_ret_sequencer

Overview:
- Program-counter sequencer for the micro: owns the PC and the subroutine return-address stack.
- Decodes BSR (branch to subroutine) and RET from the instruction decoder.
  - BSR pushes the return address PC+1 and jumps to the target.
  - RET pops the return address into the PC.
- Sits between the instruction decoder and the program memory address bus.
- Stack overflow and underflow are reported, not silently corrupted.

Parameters:
- ADDR_W, 8, width of PC, target and stack entries.
- DEPTH, 4, number of return-address entries (>=2).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  advance enable; 0 freezes all state
- bsr  input  1  branch-to-subroutine command, sampled when en=1
- ret  input  1  return command, sampled when en=1
- target  input  ADDR_W  BSR jump address, sampled with bsr
- err_clr  input  1  clears sticky error bits
- pc  output  ADDR_W  current program counter (registered)
- top  output  ADDR_W  current top-of-stack entry; 0 when empty
- depth  output  $clog2(DEPTH+1)  number of valid entries
- empty  output  1  depth==0
- full  output  1  depth==DEPTH
- err  output  3  sticky {conflict, underflow, overflow}

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, depth=0, all entries=0, err=0, top=0, empty=1, full=0.
  - Takes effect immediately, with no clock edge required, including mid-operation.
- All outputs are registered or derived only from registers. Commands take effect at the sampling edge and are visible after it (1-cycle latency).
- en=0: pc, stack, depth and err all hold. err_clr is still honoured.
- With en=1 the command is one of the following; PC arithmetic is modulo 2^ADDR_W (0xFF+1 = 0x00).
  - Neither bsr nor ret: pc <= pc+1.
  - bsr only, not full:
    - push pc+1 on top, pc <= target, depth+1.
  - bsr only, full:
    - oldest (bottom) entry discarded; stack shifts down.
    - push pc+1, pc <= target, depth stays DEPTH, err[0] set.
  - ret only, not empty: pc <= top, pop, depth-1.
  - ret only, empty: treated as plain increment, pc <= pc+1, err[1] set.
  - bsr and ret together:
    - illegal; pc, stack and depth hold, err[2] set.
- Sticky errors:
  - err_clr=1 clears err at the edge.
  - If a new error event occurs in the same cycle, that bit is set (set wins over clear).
- Stack storage: DEPTH x ADDR_W registers. Shift-register or pointer implementation is allowed, but discard-oldest on overflow is mandatory.
- top reflects the post-edge state; it is the value pc will take on the next valid RET.

Test Plan (ADDR_W=8, DEPTH=4, RESET_PC=0):
1. Plain increment and wrap:
   - Release reset, en=1 for 3 cycles -> pc 0x00,0x01,0x02,0x03.
   - Force pc to 0xFF via bsr, then ret and re-enter, then one plain increment -> pc 0x00.
2. Single call/return:
   - At pc=0x10, bsr with target=0x40 -> pc=0x40, depth=1, top=0x11.
   - Next cycle ret -> pc=0x11, depth=0, empty=1, err=0.
3. Overflow, then full unwind and underflow:
   - From pc=0x00, five consecutive bsr with targets 0x10,0x20,0x30,0x40,0x50.
     - Pushed addresses are 0x01,0x11,0x21,0x31,0x41.
     - 0x01 is discarded; full=1, depth=4, err=3'b001.
   - Four ret -> pc 0x41,0x31,0x21,0x11.
   - Fifth ret -> pc=0x12, err=3'b011.
4. Conflict and clear:
   - depth=1, pc=0x40, bsr=ret=1 -> pc=0x40, depth=1, err[2]=1.
   - err_clr=1 -> err=0.
   - err_clr=1 together with a ret on an empty stack -> err[1] remains 1.
5. Enable freeze:
   - depth=2, en=0 with bsr=1 for 3 cycles -> pc, top, depth unchanged.
   - en=1 -> bsr executes once.
6. Async reset mid-operation:
   - depth=3, err=3'b001, pc=0x35; pull rst_n low between clock edges.
   - -> pc=0x00, depth=0, err=0, top=0 before the next edge.
   - Hold for 2 edges: no change.
